// File: rtl/hb_pkg.sv
// Shared constants and types for the 2x halfband interpolator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hb_pkg;

  typedef logic signed [15:0] coef_t;
  typedef logic signed [37:0] acc_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Non-zero, non-center halfband taps c[0..6] (Q15); c[k] pairs d[k] with d[13-k].
  localparam coef_t HB_COEF [7] = '{
    16'sd3, -16'sd25, 16'sd117, -16'sd394, 16'sd1078, -16'sd2753, 16'sd10165
  };

  // Center tap is 0.5 in Q15; with gain 2 the output scale is acc / 2^14.
  localparam coef_t HB_CENTER = 16'sd16384;
  localparam int    HB_SHIFT  = $clog2(HB_CENTER);

  // Coefficient lookup; index 7 (MAC drain cycle) yields zero.
  function automatic coef_t hb_coef(input logic [2:0] k);
    coef_t c;
    c = '0;
    if (k <= 3'd6) c = HB_COEF[k];
    return c;
  endfunction

endpackage

// File: rtl/hb_mac.sv
// Pair-add, multiply and accumulate datapath for the phase-A polyphase branch.
// Latency: one cycle per accumulated term; o_acc reflects the sum of all enabled terms.
// Backpressure: none; i_clr has priority over i_en.
module hb_mac
  import hb_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic signed [15:0] i_a,
  input  logic signed [15:0] i_b,
  input  logic signed [15:0] i_coef,
  output acc_t               o_acc
);

  logic signed [16:0] w_pair;
  logic signed [32:0] w_prod;
  acc_t               r_acc;

  assign w_pair = $signed({i_a[15], i_a}) + $signed({i_b[15], i_b});
  assign w_prod = w_pair * i_coef;
  assign o_acc  = r_acc;

  // Accumulator: cleared at sample acceptance, adds one symmetric pair per enabled cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + acc_t'(w_prod);
    end
  end

endmodule

// File: rtl/hb_interp.sv
// 2x halfband interpolator (27 taps, gain 2), polyphase, one shared multiplier. HB_INTERP_SAT_EN saturates phase A.
// Latency: phase A strobes 8 cycles after acceptance, phase B HALF_PERIOD cycles later.
// Backpressure: x_in_ready high only when idle; a strobe while busy is dropped and sets sticky overrun.
module hb_interp
  import hb_pkg::*;
#(
  parameter int HALF_PERIOD = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic signed [15:0] x_in,
  input  logic               x_in_valid,
  output logic               x_in_ready,
  output logic signed [15:0] y_out,
  output logic               y_out_valid,
  output logic               y_out_phase,
  output logic               overrun
);

  localparam logic [15:0] HOLD_LAST = 16'(HALF_PERIOD - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_k;
  logic [15:0]        r_hold;
  logic signed [15:0] r_d [14];
  logic signed [15:0] r_y;
  logic               r_y_vld;
  logic               r_y_ph;
  logic               r_ovr;

  logic               w_accept;
  logic               w_mac_clr;
  logic               w_mac_en;
  logic               w_ld_a;
  logic               w_ld_b;
  logic [3:0]         w_ia;
  logic [3:0]         w_ib;
  acc_t               w_acc;
  acc_t               w_shift;
  logic signed [15:0] w_res_a;

  assign x_in_ready  = (r_state == S_IDLE);
  assign w_accept    = x_in_valid & x_in_ready;
  assign y_out       = r_y;
  assign y_out_valid = r_y_vld;
  assign y_out_phase = r_y_ph;
  assign overrun     = r_ovr;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and per-cycle datapath controls
  always_comb begin
    w_state_nxt = r_state;
    w_mac_clr   = 1'b0;
    w_mac_en    = 1'b0;
    w_ld_a      = 1'b0;
    w_ld_b      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_MAC;
          w_mac_clr   = 1'b1;
        end
      end
      S_MAC: begin
        if (r_k == 3'd7) begin
          w_state_nxt = S_HOLD;
          w_ld_a      = 1'b1;
        end else begin
          w_mac_en = 1'b1;
        end
      end
      S_HOLD: begin
        if (r_hold == HOLD_LAST) begin
          w_state_nxt = S_IDLE;
          w_ld_b      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Tap index k: restarts on acceptance, steps once per accumulated pair
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_k <= '0;
    else if (w_mac_clr) r_k <= '0;
    else if (w_mac_en)  r_k <= r_k + 3'd1;
  end

  // HOLD dwell counter, restarted at the phase-A strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               r_hold <= '0;
    else if (w_ld_a)            r_hold <= '0;
    else if (r_state == S_HOLD) r_hold <= r_hold + 16'd1;
  end

  // Delay line: shifts only on an accepted sample, d[0] newest
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 14; i++) r_d[i] <= '0;
    end else if (w_accept) begin
      r_d[0] <= x_in;
      for (int i = 1; i < 14; i++) r_d[i] <= r_d[i-1];
    end
  end

  assign w_ia = {1'b0, r_k};
  assign w_ib = 4'd13 - {1'b0, r_k};

  hb_mac u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_mac_clr),
    .i_en    (w_mac_en),
    .i_a     (r_d[w_ia]),
    .i_b     (r_d[w_ib]),
    .i_coef  (hb_coef(r_k)),
    .o_acc   (w_acc)
  );

  assign w_shift = w_acc >>> HB_SHIFT;

`ifdef HB_INTERP_SAT_EN
  localparam acc_t SAT_HI = acc_t'(32767);
  localparam acc_t SAT_LO = acc_t'(-32768);

  // Clamp the scaled phase-A sum into Q15 range
  always_comb begin
    w_res_a = w_shift[15:0];
    if (w_shift > SAT_HI)      w_res_a = 16'sh7fff;
    else if (w_shift < SAT_LO) w_res_a = 16'sh8000;
  end
`else
  // Two's-complement wrap: upper bits of the scaled sum are discarded
  logic w_unused_hi;
  assign w_res_a     = w_shift[15:0];
  assign w_unused_hi = ^w_shift[37:16];
`endif

  // Output register: single-cycle strobes, value held between them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_y     <= '0;
      r_y_vld <= 1'b0;
      r_y_ph  <= 1'b0;
    end else begin
      r_y_vld <= 1'b0;
      if (w_ld_a) begin
        r_y     <= w_res_a;
        r_y_vld <= 1'b1;
        r_y_ph  <= 1'b0;
      end else if (w_ld_b) begin
        r_y     <= r_d[6];
        r_y_vld <= 1'b1;
        r_y_ph  <= 1'b1;
      end
    end
  end

  // Sticky overrun on any strobe the block could not take
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     r_ovr <= 1'b0;
    else if (x_in_valid && !x_in_ready) r_ovr <= 1'b1;
  end

endmodule

// File: tb/tb_hb_interp.sv
// Testbench for hb_interp: randomized and directed samples against a pair-sum reference model.
// Latency: checks phase-A at 8 cycles after acceptance and phase-B HALF_PERIOD later.
// Backpressure: checks ready, dropped strobes and sticky overrun.
module tb_hb_interp;

  localparam int HP8 = 8;
  localparam int HP4 = 4;
  localparam int HP1 = 1;

  localparam longint C [7] = '{3, -25, 117, -394, 1078, -2753, 10165};
  localparam longint IMP_A [14] = '{3, -25, 117, -394, 1078, -2753, 10165,
                                    10165, -2753, 1078, -394, 117, -25, 3};
  localparam logic [13:0] SAT_NEG = 14'b01010100101010;

  logic clk = 1'b0;
  logic reset_n;
  logic signed [15:0] x_in;
  logic v8, v4, v1;
  logic rdy8, rdy4, rdy1;
  logic signed [15:0] y8, y4, y1;
  logic yv8, yv4, yv1, yp8, yp4, yp1, ov8, ov4, ov1;

  int n_chk = 0;
  int n_err = 0;
  longint h [14];

  always #5 clk = ~clk;

  hb_interp #(.HALF_PERIOD(HP8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .x_in(x_in), .x_in_valid(v8), .x_in_ready(rdy8),
    .y_out(y8), .y_out_valid(yv8), .y_out_phase(yp8), .overrun(ov8));
  hb_interp #(.HALF_PERIOD(HP4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .x_in(x_in), .x_in_valid(v4), .x_in_ready(rdy4),
    .y_out(y4), .y_out_valid(yv4), .y_out_phase(yp4), .overrun(ov4));
  hb_interp #(.HALF_PERIOD(HP1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .x_in(x_in), .x_in_valid(v1), .x_in_ready(rdy1),
    .y_out(y1), .y_out_valid(yv1), .y_out_phase(yp1), .overrun(ov1));

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 14; i++) h[i] = 0;
  endtask

  task automatic model_push(input longint x);
    for (int i = 13; i > 0; i--) h[i] = h[i-1];
    h[0] = x;
  endtask

  // Expected phase A from the current history: symmetric pair sums, scaled by 2/32768.
  function automatic longint ref_a();
    longint acc;
    longint s;
    acc = 0;
    for (int k = 0; k < 7; k++) acc += C[k] * (h[k] + h[13-k]);
    s = acc >>> 14;
`ifdef HB_INTERP_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`else
    s = s & 64'hFFFF;
    if (s >= 32768) s -= 65536;
`endif
    return s;
  endfunction

  // One sample through the HP=8 instance; optional stray strobe at E3.
  task automatic run8(input logic signed [15:0] x, input bit ovr, output longint a, output longint b);
    int a_cyc, b_cyc, nstb, hold_bad, wt;
    logic signed [15:0] a16;
    a_cyc = -1; b_cyc = -1; nstb = 0; hold_bad = 0; wt = 0; a = 0; b = 0; a16 = '0;
    @(negedge clk);
    while (!rdy8 && wt < 100) begin
      @(negedge clk);
      wt++;
    end
    chk("ready_wait", longint'(wt < 100), 1);
    x_in = x;
    v8 = 1'b1;
    model_push(longint'(x));
    for (int cyc = 0; cyc < HP8 + 20 && b_cyc < 0; cyc++) begin
      @(negedge clk);
      v8 = ovr && (cyc == 2);
      if (ovr && cyc == 2) begin
        x_in = 16'sh5a5a;
        chk("ovr_before", ov8, 0);
      end
      if (ovr && cyc == 3) chk("ovr_after", ov8, 1);
      if (yv8) begin
        nstb++;
        if (!yp8) begin
          a = y8; a16 = y8; a_cyc = cyc;
        end else begin
          b = y8; b_cyc = cyc;
        end
      end else if (a_cyc >= 0 && y8 !== a16) begin
        hold_bad++;
      end
    end
    chk("phaseA_val", a, ref_a());
    chk("phaseB_val", b, h[6]);
    chk("phaseA_cycle", a_cyc, 8);
    chk("ab_gap", b_cyc - a_cyc, HP8);
    chk("strobe_count", nstb, 2);
    chk("y_hold", hold_bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    longint a, b;
    logic [31:0] r32;
    logic signed [15:0] xs;
    int seen, cnt;

    reset_n = 1'b0; x_in = '0; v8 = 1'b0; v4 = 1'b0; v1 = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_y", y8, 0);
    chk("rst_vld", yv8, 0);
    chk("rst_phase", yp8, 0);
    chk("rst_ready", rdy8, 1);
    chk("rst_overrun", ov8, 0);
    reset_n = 1'b1;

    // Impulse
    for (int i = 0; i < 14; i++) begin
      run8((i == 0) ? 16'sd16384 : 16'sd0, 1'b0, a, b);
      chk("imp_A", a, IMP_A[i]);
      chk("imp_B", b, (i == 6) ? 16384 : 0);
    end

    // Stray strobe during MAC
    r32 = $urandom;
    run8(r32[15:0], 1'b1, a, b);

    // DC
    for (int i = 0; i < 20; i++) begin
      run8(16'sd1000, 1'b0, a, b);
      if (i >= 14) begin
        chk("dc_A", a, 999);
        chk("dc_B", b, 1000);
      end
    end

    // Worst-case magnitude
    for (int j = 13; j >= 0; j--) run8(SAT_NEG[j] ? -16'sd32768 : 16'sd32767, 1'b0, a, b);
`ifdef HB_INTERP_SAT_EN
    chk("sat_A", a, 32767);
`else
    chk("wrap_A", a, -7398);
`endif

    // Random
    for (int i = 0; i < 40; i++) begin
      r32 = $urandom;
      xs = r32[15:0];
      if (r32[21:20] == 2'd0) xs = r32[19] ? 16'sh7fff : 16'sh8000;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run8(xs, 1'b0, a, b);
    end

    // Reset during HOLD on the HP=4 instance
    @(negedge clk);
    r32 = $urandom;
    x_in = r32[15:0];
    v4 = 1'b1;
    @(negedge clk);
    v4 = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      if (yv4 && !yp4) seen = 1;
      else @(negedge clk);
    end
    chk("r4_a_seen", seen, 1);
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("r4_rst_y", y4, 0);
    chk("r4_rst_vld", yv4, 0);
    chk("r4_rst_ready", rdy4, 1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (yv4) cnt++;
    end
    chk("r4_no_strobe", cnt, 0);
    r32 = $urandom;
    xs = r32[15:0];
    x_in = xs;
    v4 = 1'b1;
    @(negedge clk);
    v4 = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      if (yv4 && !yp4) seen = 1;
      else @(negedge clk);
    end
    chk("r4_first_tap", y4, (3 * longint'(xs)) >>> 14);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (yv4) seen = 1;
    end
    chk("r4_phaseB", y4, 0);
    chk("r4_phaseB_flag", yp4, 1);

    // Strobe timing on the HP=1 instance, plus a strobe in the return-to-idle cycle
    @(negedge clk);
    chk("t1_ovr_before", ov1, 0);
    r32 = $urandom;
    x_in = r32[15:0];
    v1 = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      v1 = (cyc == 8);
      chk("t1_vld", yv1, longint'(cyc == 8 || cyc == 9));
      if (cyc == 8 || cyc == 9) chk("t1_phase", yp1, longint'(cyc == 9));
      chk("t1_ready", rdy1, longint'(cyc >= 9));
    end
    chk("t1_overrun", ov1, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
